// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/country traffic controller and its country-road car detector.
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'd0,
        LIGHT_YELLOW = 2'd1,
        LIGHT_GREEN  = 2'd2
    } light_e;

    typedef enum logic [2:0] {
        DET_IDLE    = 3'd0,
        DET_QUALIFY = 3'd1,
        DET_REQUEST = 3'd2,
        DET_SERVE   = 3'd3,
        DET_RELEASE = 3'd4
    } det_state_e;

    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_HOLD_CYC     = 3;
    localparam int RUN_CNT_W        = 8;

    function automatic logic light_is_green(input logic [1:0] light);
        return light == LIGHT_GREEN;
    endfunction

    // The unused encoding 2'd3 counts as RED so a corrupted light never strands the detector.
    function automatic logic light_is_red(input logic [1:0] light);
        return (light == LIGHT_RED) || (light == 2'd3);
    endfunction

endpackage

// File: rtl/country_car_detector_run_counter.sv
// Clearable consecutive-event counter; `last` flags that one more event reaches the terminal count.
module run_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == (term - W'(1)));

endmodule

// File: rtl/country_car_detector.sv
// Debounces the country-road loop detector and holds the controller request until the vehicle is served.
module country_car_detector
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             car_raw,
    input  logic [1:0]       country,
    output logic             ctrl,
    output logic             busy,
    output logic [CNT_W-1:0] served_cnt
);

    det_state_e             state_q;
    det_state_e             state_d;
    logic                   ctrl_q;
    logic                   ctrl_d;
    logic                   busy_q;
    logic                   busy_d;
    logic [CNT_W-1:0]       served_q;
    logic [CNT_W-1:0]       served_d;
    logic                   cnt_clr_s;
    logic                   cnt_inc_s;
    logic                   cnt_last_s;
    logic [RUN_CNT_W-1:0]   cnt_term_s;
    logic                   green_s;

    assign green_s = light_is_green(country);

    // One counter serves both the debounce run and the hold-off run; only the terminal differs.
    always_comb begin
        if (state_q == DET_SERVE) begin
            cnt_term_s = RUN_CNT_W'(HOLD_CYC);
        end else begin
            cnt_term_s = RUN_CNT_W'(DEBOUNCE_CYC);
        end
    end

    run_counter #(.W(RUN_CNT_W)) u_run_counter (
        .clk  (clk),
        .rst  (clear),
        .clr  (cnt_clr_s),
        .inc  (cnt_inc_s),
        .term (cnt_term_s),
        .last (cnt_last_s)
    );

    // Next-state and counter control.
    always_comb begin
        state_d   = state_q;
        served_d  = served_q;
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        case (state_q)
            DET_IDLE: begin
                if (car_raw && cnt_last_s) begin
                    state_d   = DET_REQUEST;
                    cnt_clr_s = 1'b1;
                end else if (car_raw) begin
                    state_d   = DET_QUALIFY;
                    cnt_inc_s = 1'b1;
                end else begin
                    cnt_clr_s = 1'b1;
                end
            end
            DET_QUALIFY: begin
                if (!car_raw) begin
                    state_d   = DET_IDLE;
                    cnt_clr_s = 1'b1;
                end else if (cnt_last_s) begin
                    state_d   = DET_REQUEST;
                    cnt_clr_s = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            DET_REQUEST: begin
                cnt_clr_s = 1'b1;
                if (green_s) begin
                    state_d = DET_SERVE;
                end else begin
                    state_d = DET_REQUEST;
                end
            end
            DET_SERVE: begin
                // A controller override out of GREEN beats a completing hold count.
                if (!green_s) begin
                    state_d   = DET_REQUEST;
                    cnt_clr_s = 1'b1;
                end else if (car_raw) begin
                    cnt_clr_s = 1'b1;
                end else if (cnt_last_s) begin
                    state_d   = DET_RELEASE;
                    cnt_clr_s = 1'b1;
                    served_d  = served_q + CNT_W'(1);
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            DET_RELEASE: begin
                cnt_clr_s = 1'b1;
                if (light_is_red(country)) begin
                    state_d = DET_IDLE;
                end else begin
                    state_d = DET_RELEASE;
                end
            end
            default: begin
                state_d   = DET_IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        ctrl_d = (state_d == DET_REQUEST) || (state_d == DET_SERVE);
        busy_d = (state_d != DET_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= DET_IDLE;
            ctrl_q   <= 1'b0;
            busy_q   <= 1'b0;
            served_q <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            busy_q   <= busy_d;
            served_q <= served_d;
        end
    end

    assign ctrl       = ctrl_q;
    assign busy       = busy_q;
    assign served_cnt = served_q;

endmodule
